// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: drives the instruction-memory address, waits RD_WAIT clocks per read
// and hands each fetched word to decode over a valid/ready handshake, with redirect and fault handling.
module instr_fetch_sequencer #(
   parameter int unsigned RD_WAIT   = 2,
   parameter logic [63:0] MEM_BYTES = 64'h060
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic [63:0] startpc,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [63:0] inst_pc,
   output logic        fetch_err
);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD, HALT} state_t;

   localparam int unsigned   CW       = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(RD_WAIT - 1);

   state_t        state;
   logic [63:0]   pc;
   logic [CW-1:0] cnt;
   logic          accept;
   logic [63:0]   seq_pc;

   // A PC is unusable if it lies past the end of memory or is not word aligned.
   function automatic logic bad_pc(input logic [63:0] a);
      return (a >= MEM_BYTES) || (a[1:0] != 2'b00);
   endfunction

   assign accept    = inst_valid && inst_ready;
   assign seq_pc    = pc + 64'd4;
   assign imem_addr = pc;

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state      <= IDLE;
         pc         <= '0;
         cnt        <= '0;
         inst       <= '0;
         inst_pc    <= '0;
         inst_valid <= 1'b0;
         fetch_err  <= 1'b0;
      end else if (state == IDLE) begin
         if (!stall) begin
            pc  <= startpc;
            cnt <= '0;
            if (bad_pc(startpc)) begin
               state     <= HALT;
               fetch_err <= 1'b1;
            end else begin
               state <= WAIT;
            end
         end
      end else if (redirect_valid) begin
         // Redirect cancels any in-flight read or unaccepted word; an accepted word still counts.
         pc         <= redirect_pc;
         cnt        <= '0;
         inst_valid <= 1'b0;
         if (bad_pc(redirect_pc)) begin
            state     <= HALT;
            fetch_err <= 1'b1;
         end else begin
            state     <= WAIT;
            fetch_err <= 1'b0;
         end
      end else begin
         unique case (state)
            WAIT: begin
               if (cnt == CNT_LAST) begin
                  inst       <= imem_data;
                  inst_pc    <= pc;
                  inst_valid <= 1'b1;
                  state      <= HOLD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (accept) begin
                  inst_valid <= 1'b0;
                  pc         <= seq_pc;
                  if (bad_pc(seq_pc)) begin
                     state     <= HALT;
                     fetch_err <= 1'b1;
                  end else if (!stall) begin
                     cnt   <= '0;
                     state <= WAIT;
                  end
               end else if (!inst_valid && !stall) begin
                  cnt   <= '0;
                  state <= WAIT;
               end
            end
            HALT: state <= HALT;
            IDLE: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Scoreboard bench for instr_fetch_sequencer: a transaction-level PC model predicts the stream of
// presented words; a monitor compares every presented/accepted word and the fault flag.
module tb_instr_fetch_sequencer;

   localparam logic [63:0] MEM_BYTES = 64'h060;

   logic        CLK = 1'b0;
   logic        resetl;
   logic [63:0] startpc;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [63:0] imem_addr;
   logic [31:0] imem_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        fetch_err;

   instr_fetch_sequencer #(.RD_WAIT(2), .MEM_BYTES(MEM_BYTES)) dut (
      .CLK(CLK), .resetl(resetl), .startpc(startpc), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc), .fetch_err(fetch_err)
   );

   always #5 CLK = ~CLK;

   logic [31:0] mem [0:31];
   assign imem_data = (imem_addr < MEM_BYTES) ? mem[imem_addr[6:2]] : 32'hDEADBEEF;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] word;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   logic [63:0] m_pc;
   bit          m_idle, m_halt, exp_err, mon_en;
   int          checks, errors, hs_cnt, idle_cyc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [63:0] a);
      return (a < MEM_BYTES) && (a[1:0] == 2'b00);
   endfunction

   // Loading a PC either queues the word it will fetch or halts the model.
   task automatic launch(input logic [63:0] a);
      m_pc = a;
      if (legal(a)) begin
         m_halt = 1'b0;
         q.push_back({a, mem[a[6:2]]});
      end else begin
         m_halt = 1'b1;
      end
   endtask

   // Drive inputs for the next edge and advance the model to what that edge will do.
   task automatic cycle(input bit s, input bit r, input bit rv, input logic [63:0] rpc);
      bit hs;
      @(posedge CLK); #1;
      exp_err        = m_halt;
      stall          = s;
      inst_ready     = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      hs             = inst_valid && r;
      if (m_idle) begin
         if (!s) begin
            m_idle = 1'b0;
            launch(startpc);
         end
      end else if (rv) begin
         if (!hs && q.size() > 0) void'(q.pop_back());
         launch(rpc);
      end else if (hs) begin
         launch(m_pc + 64'd4);
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!inst_valid && n < 20) begin
         cycle(1'b0, 1'b0, 1'b0, 64'd0);
         n++;
      end
      check(name, {63'd0, inst_valid}, 64'd1);
   endtask

   always @(negedge CLK) begin
      if (resetl && mon_en) begin
         check("fetch_err", {63'd0, fetch_err}, {63'd0, exp_err});
         if (inst_valid) begin
            idle_cyc = 0;
            if (q.size() == 0) begin
               check("unexpected_word", inst_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else if (inst_ready) begin
               mon_e = q.pop_front();
               hs_cnt++;
               check("accept_pc", inst_pc, mon_e.pc);
               check("accept_inst", {32'd0, inst}, {32'd0, mon_e.word});
            end else if (!redirect_valid) begin
               mon_e = q[0];
               check("hold_pc", inst_pc, mon_e.pc);
               check("hold_inst", {32'd0, inst}, {32'd0, mon_e.word});
            end
         end else if (q.size() > 0 && !stall) begin
            idle_cyc++;
            if (idle_cyc == 40) check("fetch_timeout", 64'(idle_cyc), 64'd0);
         end else begin
            idle_cyc = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      bit          s, r, rv;
      logic [63:0] rpc;
      checks = 0; errors = 0; hs_cnt = 0; idle_cyc = 0;
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[0] = 32'hF84003E9;
      mem[1] = 32'hF84083EA;
      mem[2] = 32'hF84103EB;
      mem[5] = 32'hAA0B014A;
      resetl = 1'b0; startpc = 64'd0; stall = 1'b1; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 64'd0;
      m_idle = 1'b1; m_halt = 1'b0; exp_err = 1'b0; m_pc = 64'd0; mon_en = 1'b1;
      repeat (3) @(negedge CLK);
      #1;
      check("rst_valid", {63'd0, inst_valid}, 64'd0);
      check("rst_addr", imem_addr, 64'd0);
      check("rst_inst_pc", inst_pc, 64'd0);
      check("rst_err", {63'd0, fetch_err}, 64'd0);
      resetl = 1'b1;

      // Sequential fetch from 0: three words in twelve edges.
      repeat (12) cycle(1'b0, 1'b1, 1'b0, 64'd0);
      check("throughput", 64'(hs_cnt), 64'd3);

      // Backpressure at 0x14, then release.
      cycle(1'b0, 1'b0, 1'b1, 64'h14);
      repeat (7) cycle(1'b0, 1'b0, 1'b0, 64'd0);
      check("held_inst", {32'd0, inst}, 64'hAA0B014A);
      repeat (6) cycle(1'b0, 1'b1, 1'b0, 64'd0);

      // Redirect while waiting on 0x2C.
      cycle(1'b0, 1'b1, 1'b1, 64'h2C);
      cycle(1'b0, 1'b1, 1'b1, 64'h1C);
      repeat (6) cycle(1'b0, 1'b1, 1'b0, 64'd0);

      // Redirect and accept on the same edge at 0x28.
      cycle(1'b0, 1'b0, 1'b1, 64'h28);
      wait_valid("wait_0x28");
      cycle(1'b0, 1'b1, 1'b1, 64'h40);
      repeat (6) cycle(1'b0, 1'b1, 1'b0, 64'd0);

      // Fault: run off the end, misaligned redirect, then recover.
      cycle(1'b0, 1'b1, 1'b1, 64'h58);
      repeat (12) cycle(1'b0, 1'b1, 1'b0, 64'd0);
      check("end_fault_err", {63'd0, fetch_err}, 64'd1);
      check("end_fault_valid", {63'd0, inst_valid}, 64'd0);
      cycle(1'b0, 1'b1, 1'b1, 64'h02);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 64'd0);
      check("misalign_err", {63'd0, fetch_err}, 64'd1);
      cycle(1'b0, 1'b1, 1'b1, 64'h00);
      cycle(1'b0, 1'b1, 1'b0, 64'd0);
      check("recover_err", {63'd0, fetch_err}, 64'd0);
      repeat (6) cycle(1'b0, 1'b1, 1'b0, 64'd0);

      // Reset in the middle of a read.
      cycle(1'b0, 1'b1, 1'b1, 64'h30);
      cycle(1'b0, 1'b1, 1'b0, 64'd0);
      resetl = 1'b0;
      #1;
      check("midrst_valid", {63'd0, inst_valid}, 64'd0);
      check("midrst_addr", imem_addr, 64'd0);
      check("midrst_inst", {32'd0, inst}, 64'd0);
      check("midrst_inst_pc", inst_pc, 64'd0);
      check("midrst_err", {63'd0, fetch_err}, 64'd0);
      q.delete();
      m_idle = 1'b1; m_halt = 1'b0; exp_err = 1'b0;
      startpc = 64'h34; stall = 1'b1; redirect_valid = 1'b0;
      @(negedge CLK); #2;
      resetl = 1'b1;
      wait_valid("wait_0x34");
      check("restart_pc", inst_pc, 64'h34);
      repeat (4) cycle(1'b0, 1'b1, 1'b0, 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 2500; i++) begin
         s  = ($urandom_range(0, 99) < 15);
         r  = ($urandom_range(0, 99) < 70);
         rv = ($urandom_range(0, 99) < 5);
         if ($urandom_range(0, 9) == 0) rpc = 64'($urandom_range(0, 127));
         else                            rpc = 64'($urandom_range(0, 23)) << 2;
         cycle(s, r, rv, rpc);
      end
      check("progress", 64'(hs_cnt > 200), 64'd1);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
